// File: rtl/fb_scan_reader_pkg.sv
// Shared types and constants for the frame-buffer scan reader.
// Holds the FSM encoding, pixel width and default frame geometry.
package fb_scan_reader_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   localparam int PIX_W           = 16;
   localparam int H_ACTIVE        = 640;
   localparam int V_ACTIVE        = 480;
   localparam int FRAME_WORDS_DEF = H_ACTIVE * V_ACTIVE;

endpackage

// File: rtl/fb_scan_reader_fifo.sv
// First-word-fall-through FIFO: head word is visible while not empty.
// Ports: clk_i, rst_ni, flush_i, push_i/push_data_i, pop_i/pop_data_o,
// fill_o (word count), empty_o. Output data reads 0 when empty.
module fb_fwft_fifo
   import fb_scan_reader_pkg::*;
#(
   parameter int WIDTH = PIX_W,
   parameter int DEPTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic [$clog2(DEPTH):0] fill_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             full, do_push, do_pop;

   // Extra pointer MSB separates full from empty at equal indices.
   assign full = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty_o = (wptr_q == rptr_q);
   assign fill_o  = wptr_q - rptr_q;

   // A push into a full FIFO is dropped.
   assign do_push = push_i && !full && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + ONE;
         if (do_pop)  rptr_d = rptr_q + ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
   end

   assign pop_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/fb_scan_reader.sv
// Frame-buffer scan reader: burst reads from SDRAM into a FWFT FIFO.
// Ports: iCLK/iRESETn, iFRAME_START, oRD_REQ/oRD_ADDR/iRD_GNT,
// iRD_DATA/iRD_DATA_VALID, iPIX_REQ, oPIX_DATA/oPIX_VALID, oUNDERFLOW.
module fb_scan_reader
   import fb_scan_reader_pkg::*;
#(
   parameter int ADDR_W      = 22,
   parameter int BASE_ADDR   = 0,
   parameter int FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int BURST       = 8,
   parameter int DEPTH       = 32
) (
   input  logic              iCLK,
   input  logic              iRESETn,
   input  logic              iFRAME_START,
   output logic              oRD_REQ,
   output logic [ADDR_W-1:0] oRD_ADDR,
   input  logic              iRD_GNT,
   input  logic [PIX_W-1:0]  iRD_DATA,
   input  logic              iRD_DATA_VALID,
   input  logic              iPIX_REQ,
   output logic [PIX_W-1:0]  oPIX_DATA,
   output logic              oPIX_VALID,
   output logic              oUNDERFLOW
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_A =
      ADDR_W'(BASE_ADDR + FRAME_WORDS - BURST);
   localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(BURST);
   localparam logic [CW-1:0]     BURST_C = CW'(BURST);
   localparam logic [CW-1:0]     ONE_C   = CW'(1);
   localparam logic [CW:0]       START_LIM = (CW+1)'(DEPTH - BURST);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CW-1:0]     outst_q, outst_d;
   logic [CW-1:0]     drain_q, drain_d;
   logic              unf_q, unf_d;

   logic [CW-1:0]     fill;
   logic [CW:0]       used;
   logic              empty, grant, in_flight, push, start_ok;

   // Granted-but-unreturned words count as occupied space.
   assign used     = {1'b0, fill} + {1'b0, outst_q};
   assign start_ok = (used <= START_LIM);
   assign grant    = (state_q == S_REQ) && iRD_GNT;

   // Valid pulses with nothing outstanding (e.g. after reset) are ignored.
   assign in_flight = iRD_DATA_VALID && (outst_q != '0);
   assign push = in_flight && (drain_q == '0) && !iFRAME_START;

   always_comb begin
      addr_d  = addr_q;
      outst_d = outst_q;
      drain_d = drain_q;
      unf_d   = unf_q;

      if (grant) begin
         addr_d  = (addr_q == LAST_A) ? BASE_A : addr_q + STEP_A;
         outst_d = outst_d + BURST_C;
      end
      if (in_flight) outst_d = outst_d - ONE_C;
      if (in_flight && (drain_q != '0)) drain_d = drain_q - ONE_C;
      if (iPIX_REQ && empty) unf_d = 1'b1;

      // Everything still in flight after this cycle belongs to the old frame.
      if (iFRAME_START) begin
         addr_d  = BASE_A;
         drain_d = outst_d;
         unf_d   = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_ok && (drain_q == '0) && !iFRAME_START)
               state_d = S_REQ;
         end
         S_REQ: begin
            if (grant)             state_d = S_WAIT;
            else if (iFRAME_START) state_d = S_IDLE;
         end
         S_WAIT: begin
            if (outst_d == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         state_q <= S_IDLE;
         addr_q  <= BASE_A;
         outst_q <= '0;
         drain_q <= '0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         outst_q <= outst_d;
         drain_q <= drain_d;
         unf_q   <= unf_d;
      end
   end

   fb_fwft_fifo #(
      .WIDTH (PIX_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i       (iCLK),
      .rst_ni      (iRESETn),
      .flush_i     (iFRAME_START),
      .push_i      (push),
      .push_data_i (iRD_DATA),
      .pop_i       (iPIX_REQ),
      .pop_data_o  (oPIX_DATA),
      .fill_o      (fill),
      .empty_o     (empty)
   );

   assign oRD_REQ    = (state_q == S_REQ);
   assign oRD_ADDR   = addr_q;
   assign oPIX_VALID = !empty;
   assign oUNDERFLOW = unf_q;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader with a burst controller model.
// Uses FRAME_WORDS=64 so the address wrap is reached quickly.
module tb_fb_scan_reader;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        fs_tb  = 1'b0;
   logic        fs_ctl = 1'b0;
   logic        frame_start;
   logic        rd_req;
   logic [21:0] rd_addr;
   logic        gnt    = 1'b0;
   logic [15:0] rdata  = '0;
   logic        vld    = 1'b0;
   logic        pop    = 1'b0;
   logic [15:0] pix;
   logic        pix_v;
   logic        unf;

   int checks = 0;
   int errors = 0;

   logic        ctl_en     = 1'b0;
   logic        fs_mid_req = 1'b0;
   logic        fs_gnt_req = 1'b0;
   logic        busy       = 1'b0;
   int          dly        = 0;
   int          idx        = 0;
   logic [21:0] gbase      = '0;
   logic [21:0] gq[$];

   assign frame_start = fs_tb | fs_ctl;

   always #5 clk = ~clk;

   fb_scan_reader #(
      .ADDR_W      (22),
      .BASE_ADDR   (0),
      .FRAME_WORDS (64),
      .BURST       (8),
      .DEPTH       (32)
   ) dut (
      .iCLK           (clk),
      .iRESETn        (rst_n),
      .iFRAME_START   (frame_start),
      .oRD_REQ        (rd_req),
      .oRD_ADDR       (rd_addr),
      .iRD_GNT        (gnt),
      .iRD_DATA       (rdata),
      .iRD_DATA_VALID (vld),
      .iPIX_REQ       (pop),
      .oPIX_DATA      (pix),
      .oPIX_VALID     (pix_v),
      .oUNDERFLOW     (unf)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   // Controller model: grant at once, 8 words starting 3 cycles later,
   // data equals word address.
   initial begin
      forever begin
         @(negedge clk);
         gnt    = 1'b0;
         vld    = 1'b0;
         fs_ctl = 1'b0;
         if (busy) begin
            if (dly != 0) begin
               dly--;
            end else begin
               if (fs_mid_req && idx == 3) fs_ctl = 1'b1;
               vld   = 1'b1;
               rdata = 16'(gbase + 22'(idx));
               idx++;
               if (idx == 8) busy = 1'b0;
            end
         end else if (ctl_en && rd_req) begin
            gnt   = 1'b1;
            gbase = rd_addr;
            busy  = 1'b1;
            dly   = 2;
            idx   = 0;
            gq.push_back(rd_addr);
            if (fs_gnt_req) fs_ctl = 1'b1;
         end
      end
   end

   initial begin
      int k;
      int n;
      int cnt;
      int g0;
      logic [31:0] exp;
      logic tog;

      repeat (3) step;
      chk("rst_req",   32'(rd_req),  32'd0);
      chk("rst_addr",  32'(rd_addr), 32'd0);
      chk("rst_pix",   32'(pix),     32'd0);
      chk("rst_valid", 32'(pix_v),   32'd0);
      chk("rst_unf",   32'(unf),     32'd0);

      rst_n = 1'b1;
      step;
      chk("first_req",  32'(rd_req),  32'd1);
      chk("first_addr", 32'(rd_addr), 32'd0);

      // Underflow with no grants
      pop = 1'b1;
      step;
      pop = 1'b0;
      chk("unf_set", 32'(unf), 32'd1);
      repeat (5) step;
      chk("unf_hold", 32'(unf), 32'd1);
      fs_tb = 1'b1;
      step;
      fs_tb = 1'b0;
      chk("unf_clr", 32'(unf), 32'd0);
      chk("fs_drop_req", 32'(rd_req), 32'd0);
      step;
      chk("re_req", 32'(rd_req), 32'd1);

      // Steady pull, pop every 2nd cycle, across the wrap
      ctl_en = 1'b1;
      exp = 0;
      n = 0;
      k = 0;
      tog = 1'b0;
      while (n < 72 && k < 2000) begin
         pop = 1'b0;
         if (tog && pix_v) begin
            chk("pull_pix", 32'(pix), exp);
            exp = (exp + 1) % 64;
            n++;
            pop = 1'b1;
         end
         tog = !tog;
         step;
         k++;
      end
      pop = 1'b0;
      chk("pull_count", 32'(n), 32'd72);
      chk("pull_unf", 32'(unf), 32'd0);
      chk("gq_size_ok", 32'(gq.size() >= 9), 32'd1);
      chk("gaddr0", 32'(gq[0]), 32'd0);
      chk("gaddr1", 32'(gq[1]), 32'd8);
      chk("gaddr2", 32'(gq[2]), 32'd16);
      chk("gaddr7", 32'(gq[7]), 32'd56);
      chk("gaddr_wrap", 32'(gq[8]), 32'd0);

      // Backpressure after a flush: exactly 4 bursts fit
      ctl_en = 1'b0;
      repeat (20) step;
      fs_tb = 1'b1;
      step;
      fs_tb = 1'b0;
      g0 = gq.size();
      ctl_en = 1'b1;
      repeat (200) step;
      chk("bp_grants", 32'(gq.size() - g0), 32'd4);
      chk("bp_req_idle", 32'(rd_req), 32'd0);
      chk("bp_valid", 32'(pix_v), 32'd1);
      exp = 0;
      n = 0;
      k = 0;
      while (n < 32 && k < 500) begin
         pop = 1'b0;
         if (pix_v) begin
            chk("bp_pix", 32'(pix), exp);
            exp++;
            n++;
            pop = 1'b1;
         end
         step;
         k++;
      end
      pop = 1'b0;
      chk("bp_count", 32'(n), 32'd32);

      // Frame start after 3 of 8 words
      ctl_en = 1'b0;
      repeat (30) step;
      fs_tb = 1'b1;
      step;
      fs_tb = 1'b0;
      fs_mid_req = 1'b1;
      ctl_en = 1'b1;
      k = 0;
      while (fs_ctl !== 1'b1 && k < 100) begin
         step;
         k++;
      end
      fs_mid_req = 1'b0;
      chk("mid_fs_seen", 32'(k < 100), 32'd1);
      chk("mid_pre_valid", 32'(pix_v), 32'd1);
      cnt = vld ? 1 : 0;
      step;
      chk("mid_valid_next", 32'(pix_v), 32'd0);
      k = 0;
      while (rd_req !== 1'b1 && k < 100) begin
         if (vld) cnt++;
         step;
         k++;
      end
      chk("mid_discard", 32'(cnt), 32'd5);
      chk("mid_addr", 32'(rd_addr), 32'd0);
      chk("mid_empty", 32'(pix_v), 32'd0);
      k = 0;
      while (pix_v !== 1'b1 && k < 100) begin
         step;
         k++;
      end
      chk("mid_first_pix", 32'(pix), 32'd0);
      pop = 1'b1;
      step;
      pop = 1'b0;

      // Grant coincident with frame start
      ctl_en = 1'b0;
      repeat (30) step;
      fs_tb = 1'b1;
      step;
      fs_tb = 1'b0;
      step;
      chk("cg_pre_req", 32'(rd_req), 32'd1);
      chk("cg_pre_addr", 32'(rd_addr), 32'd0);
      fs_gnt_req = 1'b1;
      ctl_en = 1'b1;
      k = 0;
      while (gnt !== 1'b1 && k < 20) begin
         step;
         k++;
      end
      fs_gnt_req = 1'b0;
      chk("cg_grant_seen", 32'(k < 20), 32'd1);
      cnt = 0;
      step;
      k = 0;
      while (rd_req !== 1'b1 && k < 100) begin
         if (vld) cnt++;
         step;
         k++;
      end
      chk("cg_discard", 32'(cnt), 32'd8);
      chk("cg_addr", 32'(rd_addr), 32'd0);
      chk("cg_empty", 32'(pix_v), 32'd0);
      k = 0;
      while (pix_v !== 1'b1 && k < 100) begin
         step;
         k++;
      end
      chk("cg_first_pix", 32'(pix), 32'd0);
      chk("final_unf", 32'(unf), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
